// File: rtl/data_mem_pkg.sv
// Shared types and word geometry for the data-memory responder.
// Pure definitions: no logic, no latency, no flow control.
package data_mem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_BITS  = 64;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } dm_state_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// Core-to-memory data bus: byte address, store strobe/data/mask, combinational read data.
// No handshake; the core drives addr every cycle and the memory answers in the same cycle.
interface data_mem_resp_if;

  logic [31:0] addr;
  logic        wr_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [63:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output wdata,
    output wmask,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  wdata,
    input  wmask,
    output rdata
  );

endinterface

// File: rtl/data_mem_resp_array.sv
// DEPTH x 64-bit storage: one byte-enabled synchronous write port, one combinational read port.
// Writes land at posedge; reads have zero latency; never stalls.
module dm_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        widx,
  input  logic [WORD_BYTES-1:0] wbe,
  input  logic [WORD_BITS-1:0] wd,
  input  logic [AW-1:0]        ridx,
  output logic [WORD_BITS-1:0] rd
);

  logic [WORD_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wbe[i]) begin
          mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  assign rd = mem_q[ridx];

endmodule

// File: rtl/data_mem_resp.sv
// Memory-side responder for the core data bus: zero-latency reads, byte-masked posedge stores.
// No backpressure; accesses are ignored (rdata=0, no stores) until the post-reset scrub completes.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter bit          SCRUB_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  nrst,
  data_mem_resp_if.slave        bus,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           err_addr,
  input  logic                  err_clr,
  output logic [31:0]           wr_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(WORD_BYTES);

  dm_state_t   state_q;
  logic        ready_q;
  logic [AW-1:0] scrub_idx_q;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        in_range, aligned, hit;
  logic        store_ok, store_bad, scrubbing;

  logic                  arr_we;
  logic [AW-1:0]         arr_widx;
  logic [WORD_BYTES-1:0] arr_wbe;
  logic [WORD_BITS-1:0]  arr_wd;
  logic [WORD_BITS-1:0]  arr_rd;

  // Offset wraps at 32 bits, so addresses below BASE_ADDR decode as far out of range.
  assign off      = bus.addr - BASE_ADDR;
  assign idx      = off[AW+2:3];
  assign in_range = {1'b0, off} < SPAN;
  assign aligned  = (off[2:0] == 3'b000);
  assign hit      = in_range && aligned;

  assign scrubbing = (state_q == SCRUB);
  assign store_ok  = ready_q && bus.wr_en && hit;
  assign store_bad = ready_q && bus.wr_en && !hit;

  assign arr_we   = scrubbing || store_ok;
  assign arr_widx = scrubbing ? scrub_idx_q : idx;
  assign arr_wbe  = scrubbing ? '1 : bus.wmask;
  assign arr_wd   = scrubbing ? '0 : bus.wdata;

  dm_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .widx (arr_widx),
    .wbe  (arr_wbe),
    .wd   (arr_wd),
    .ridx (idx),
    .rd   (arr_rd)
  );

  assign bus.rdata = (ready_q && hit) ? arr_rd : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCRUB_EN ? SCRUB : READY;
      ready_q     <= !SCRUB_EN;
      scrub_idx_q <= '0;
    end else begin
      case (state_q)
        SCRUB: begin
          scrub_idx_q <= scrub_idx_q + 1'b1;
          if (scrub_idx_q == AW'(DEPTH - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= READY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A new error on the same edge as err_clr is recorded rather than dropped.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (store_bad && (!err_q || err_clr)) begin
      err_d      = 1'b1;
      err_addr_d = bus.addr;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (store_ok && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a scrubbing instance and a non-scrubbing instance, scoreboard-checked.
module tb_data_mem_resp;
  import data_mem_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        err_clr_a, err_clr_b;
  logic        ready_a, ready_b, err_a, err_b;
  logic [31:0] err_addr_a, err_addr_b, wr_cnt_a, wr_cnt_b;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_b ();

  data_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE_A), .SCRUB_EN(1'b1)) dut_a (
    .clk(clk), .nrst(nrst), .bus(bus_a), .ready(ready_a), .err(err_a),
    .err_addr(err_addr_a), .err_clr(err_clr_a), .wr_cnt(wr_cnt_a)
  );

  data_mem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE_B), .SCRUB_EN(1'b0)) dut_b (
    .clk(clk), .nrst(nrst), .bus(bus_b), .ready(ready_b), .err(err_b),
    .err_addr(err_addr_b), .err_clr(err_clr_b), .wr_cnt(wr_cnt_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q [$];
  logic [31:0] cnt_q [$];
  logic [63:0] model_b [DEPTH];

  task automatic idle_all();
    bus_a.addr = BASE_A; bus_a.wr_en = 1'b0; bus_a.wdata = '0; bus_a.wmask = '0;
    bus_b.addr = BASE_B; bus_b.wr_en = 1'b0; bus_b.wdata = '0; bus_b.wmask = '0;
    err_clr_a = 1'b0; err_clr_b = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [63:0] e;
    idle_all();
    nrst = 1'b0;
    @(negedge clk);
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_a); end
    checks++; if (err_a !== 1'b0 || err_addr_a !== 32'h0) begin failures++; $display("FAIL reset_err got=%b/%h exp=0/0", err_a, err_addr_a); end
    checks++; if (wr_cnt_a !== 32'h0) begin failures++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt_a); end
    nrst = 1'b1;
    // Stores attempted during scrub must be ignored entirely.
    bus_a.wr_en = 1'b1; bus_a.wdata = '1; bus_a.wmask = '1; bus_a.addr = BASE_A + 32'd8;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ready_a === 1'b1) break;
    end
    bus_a.wr_en = 1'b0;
    checks++; if (n !== 16) begin failures++; $display("FAIL scrub_cycles got=%0d exp=16", n); end
    checks++; if (wr_cnt_a !== 32'h0 || err_a !== 1'b0) begin failures++; $display("FAIL scrub_ignore_store got=%0d/%b exp=0/0", wr_cnt_a, err_a); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus_a.addr = BASE_A + 32'(8 * i);
      exp_q.push_back(64'h0);
      #1;
      e = exp_q.pop_front();
      checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL scrub_zero[%0d] got=%h exp=%h", i, bus_a.rdata, e); end
    end
  endtask

  task automatic test_masked_store();
    logic [63:0] e;
    @(negedge clk);
    bus_a.addr = BASE_A + 32'd8; bus_a.wr_en = 1'b1;
    bus_a.wdata = 64'h1122334455667788; bus_a.wmask = 8'h0F;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0000000055667788);
    cnt_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL store_old_data got=%h exp=%h", bus_a.rdata, e); end
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL masked_store got=%h exp=%h", bus_a.rdata, e); end
    checks++; if (wr_cnt_a !== cnt_q[0]) begin failures++; $display("FAIL masked_wr_cnt got=%0d exp=%0d", wr_cnt_a, cnt_q[0]); end
    void'(cnt_q.pop_front());
  endtask

  task automatic test_misaligned();
    logic [63:0] e;
    @(negedge clk);
    bus_a.addr = BASE_A + 32'd12; bus_a.wr_en = 1'b1; bus_a.wdata = '1; bus_a.wmask = '1;
    @(negedge clk);
    bus_a.wr_en = 1'b0; bus_a.addr = BASE_A + 32'd8;
    exp_q.push_back(64'h0000000055667788);
    #1;
    checks++; if (err_a !== 1'b1 || err_addr_a !== BASE_A + 32'd12) begin failures++; $display("FAIL misalign_err got=%b/%h exp=1/%h", err_a, err_addr_a, BASE_A + 32'd12); end
    checks++; if (wr_cnt_a !== 32'd1) begin failures++; $display("FAIL misalign_wr_cnt got=%0d exp=1", wr_cnt_a); end
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL misalign_word1 got=%h exp=%h", bus_a.rdata, e); end
    @(negedge clk);
    bus_a.addr = BASE_A + 32'h1000; bus_a.wr_en = 1'b1;
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1 || err_addr_a !== BASE_A + 32'd12) begin failures++; $display("FAIL err_sticky got=%b/%h exp=1/%h", err_a, err_addr_a, BASE_A + 32'd12); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] e;
    logic [31:0] last;
    @(negedge clk);
    bus_a.addr = BASE_A + 32'(DEPTH * 8);
    exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL oor_read got=%h exp=%h", bus_a.rdata, e); end
    bus_a.addr = BASE_A - 32'd8;
    #1;
    checks++; if (bus_a.rdata !== 64'h0) begin failures++; $display("FAIL below_base_read got=%h exp=0", bus_a.rdata); end
    // Last word is the highest in-range address.
    last = BASE_A + 32'((DEPTH - 1) * 8);
    @(negedge clk);
    bus_a.addr = last; bus_a.wr_en = 1'b1; bus_a.wdata = 64'hDEAD_BEEF_0BAD_F00D; bus_a.wmask = '1;
    exp_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL last_word got=%h exp=%h", bus_a.rdata, e); end
    checks++; if (wr_cnt_a !== 32'd2) begin failures++; $display("FAIL last_word_wr_cnt got=%0d exp=2", wr_cnt_a); end
    @(negedge clk);
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
    #1;
    checks++; if (err_a !== 1'b0 || err_addr_a !== 32'h0) begin failures++; $display("FAIL err_clear got=%b/%h exp=0/0", err_a, err_addr_a); end
    @(negedge clk);
    bus_a.addr = BASE_A + 32'(DEPTH * 8); bus_a.wr_en = 1'b1;
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1 || err_addr_a !== BASE_A + 32'(DEPTH * 8)) begin failures++; $display("FAIL oor_store_err got=%b/%h exp=1/%h", err_a, err_addr_a, BASE_A + 32'(DEPTH * 8)); end
    @(negedge clk);
    bus_a.addr = BASE_A + 32'd3; bus_a.wr_en = 1'b1; err_clr_a = 1'b1;
    @(negedge clk);
    bus_a.wr_en = 1'b0; err_clr_a = 1'b0;
    #1;
    checks++; if (err_a !== 1'b1 || err_addr_a !== BASE_A + 32'd3) begin failures++; $display("FAIL clr_vs_new_err got=%b/%h exp=1/%h", err_a, err_addr_a, BASE_A + 32'd3); end
    checks++; if (wr_cnt_a !== 32'd2) begin failures++; $display("FAIL bad_store_no_count got=%0d exp=2", wr_cnt_a); end
  endtask

  task automatic test_reset_mid_scrub();
    int n;
    logic [63:0] e;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b0 || err_a !== 1'b0 || wr_cnt_a !== 32'h0) begin failures++; $display("FAIL async_reset got=%b/%b/%0d exp=0/0/0", ready_a, err_a, wr_cnt_a); end
    @(negedge clk);
    nrst = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ready_a === 1'b1) break;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL rescrub_cycles got=%0d exp=16", n); end
    bus_a.addr = BASE_A + 32'd8;
    exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_a.rdata !== e) begin failures++; $display("FAIL rescrub_word1 got=%h exp=%h", bus_a.rdata, e); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e, d;
    @(negedge clk);
    nrst = 1'b0;
    #2 nrst = 1'b1;
    #1;
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL noscrub_ready got=%b exp=1", ready_b); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = {$urandom(), $urandom()};
      bus_b.addr = BASE_B + 32'(8 * i); bus_b.wr_en = 1'b1; bus_b.wdata = d; bus_b.wmask = '1;
      model_b[i] = d;
    end
    // Partial mask over an existing word, then an empty mask that still counts.
    @(negedge clk);
    d = 64'hA5A5_5A5A_C3C3_3C3C;
    bus_b.addr = BASE_B + 32'd16; bus_b.wdata = d; bus_b.wmask = 8'hA5;
    for (int b = 0; b < 8; b++) if (bus_b.wmask[b]) model_b[2][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    bus_b.addr = BASE_B + 32'd24; bus_b.wdata = '1; bus_b.wmask = 8'h00;
    @(negedge clk);
    bus_b.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(model_b[i]);
    for (int i = 0; i < 4; i++) begin
      bus_b.addr = BASE_B + 32'(8 * i);
      #1;
      e = exp_q.pop_front();
      checks++; if (bus_b.rdata !== e) begin failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, bus_b.rdata, e); end
    end
    checks++; if (wr_cnt_b !== 32'd6) begin failures++; $display("FAIL b2b_wr_cnt got=%0d exp=6", wr_cnt_b); end
    checks++; if (err_b !== 1'b0 || err_addr_b !== 32'h0) begin failures++; $display("FAIL b2b_err got=%b/%h exp=0/0", err_b, err_addr_b); end
  endtask

  task automatic test_saturation();
    logic [31:0] c;
    @(negedge clk);
    force dut_b.wr_cnt_q = 32'hFFFF_FFFD;
    #1 release dut_b.wr_cnt_q;
    bus_b.addr = BASE_B; bus_b.wr_en = 1'b1; bus_b.wmask = 8'h00;
    cnt_q.push_back(32'hFFFF_FFFE);
    cnt_q.push_back(32'hFFFF_FFFF);
    cnt_q.push_back(32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      c = cnt_q.pop_front();
      checks++; if (wr_cnt_b !== c) begin failures++; $display("FAIL sat_wr_cnt[%0d] got=%h exp=%h", k, wr_cnt_b, c); end
    end
    bus_b.wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_masked_store();
    test_misaligned();
    test_out_of_range();
    test_reset_mid_scrub();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
